// File: rtl/seq_addsub_unit.sv
// seq_addsub_unit: multi-cycle chunked two's-complement add/subtract with CF/OF/ZF/SF flags
module seq_addsub_unit #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             sign
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] opa, opb, acc, acc_n;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] ca, cb;
  logic [CHUNK:0]   s;
  logic             carry, cmsb, last, accept;
  assign busy   = state == RUN;
  assign done   = state == DONE;
  assign last   = idx == IW'(N - 1);
  assign accept = start && state != RUN;
  // one chunk of the ripple: the carry into the top bit falls out of sum ^ a ^ b
  always_comb begin
    ca = opa[int'(idx)*CHUNK +: CHUNK];
    cb = opb[int'(idx)*CHUNK +: CHUNK];
    s = {1'b0, ca} + {1'b0, cb} + (CHUNK + 1)'(carry);
    cmsb = s[CHUNK-1] ^ ca[CHUNK-1] ^ cb[CHUNK-1];
    acc_n = acc;
    acc_n[int'(idx)*CHUNK +: CHUNK] = s[CHUNK-1:0];
  end
  // next-state: start is only honoured outside RUN
  always_comb begin
    state_n = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // operand latch, chunk accumulation and registered result/flags on entry to DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      sign      <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= op ? ~b : b;
      carry <= op;
      idx   <= '0;
      acc   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_n;
      carry <= s[CHUNK];
      idx   <= idx + IW'(1);
      if (last) begin
        result    <= acc_n;
        carry_out <= s[CHUNK];
        overflow  <= cmsb ^ s[CHUNK];
        zero      <= acc_n == '0;
        sign      <= acc_n[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_seq_addsub_unit.sv
// tb_seq_addsub_unit: scoreboard bench over four width/chunk configurations
module tb_seq_addsub_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [63:0] r;
    logic        c, v, z, s;
    int          t;
  } exp_t;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  for (genvar g = 0; g < 4; g++) begin : u
    localparam int W = g == 1 ? 16 : g == 3 ? 32 : 64;
    localparam int C = g == 0 ? 8 : g == 1 ? 4 : g == 2 ? 64 : 8;
    localparam int N = W / C;
    logic rst_n = 1'b0, start = 1'b0, op = 1'b0, fin = 1'b0;
    logic busy, done, carry_out, overflow, zero, sign;
    logic [W-1:0] a = '0, b = '0, result, last_r = '0;
    int cyc = 0;
    exp_t q[$];
    exp_t e;
    seq_addsub_unit #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .carry_out(carry_out),
      .overflow(overflow), .zero(zero), .sign(sign)
    );
    always @(posedge clk) cyc <= cyc + 1;
    task automatic ck(input string nm, input logic [63:0] got, input logic [63:0] exp);
      chk($sformatf("w%0d_c%0d_%s", W, C, nm), got, exp);
    endtask
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o, input int t);
      logic [W:0] f;
      exp_t r;
      f = o ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
      r.r = 64'(f[W-1:0]);
      r.c = o ? x >= y : f[W];
      r.v = (o ? x[W-1] != y[W-1] : x[W-1] == y[W-1]) && f[W-1] != x[W-1];
      r.z = f[W-1:0] == '0;
      r.s = f[W-1];
      r.t = t;
      return r;
    endfunction
    function automatic logic [W-1:0] rnd();
      case ($urandom_range(0, 4))
        0: return '1;
        1: return W'(1) << (W - 1);
        2: return W'($urandom_range(0, 3));
        default: return W'({$urandom, $urandom});
      endcase
    endfunction
    always @(negedge clk) if (rst_n && done) begin
      ck("busy_with_done", 64'(busy), 64'(0));
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w%0d_c%0d_unexpected_done: got done=1 expected none", W, C);
      end else begin
        e = q.pop_front();
        ck("result", 64'(result), e.r);
        ck("carry_out", 64'(carry_out), 64'(e.c));
        ck("overflow", 64'(overflow), 64'(e.v));
        ck("zero", 64'(zero), 64'(e.z));
        ck("sign", 64'(sign), 64'(e.s));
        ck("latency", 64'(cyc), 64'(e.t));
        last_r = result;
      end
    end
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
      int n = 0;
      @(negedge clk);
      while (busy && n < 500) begin
        @(negedge clk);
        n++;
      end
      ck("issue_wait", 64'(n < 500), 64'(1));
      a = x;
      b = y;
      op = o;
      start = 1'b1;
      q.push_back(model(x, y, o, cyc + N + 1));
      @(posedge clk);
      #1;
      start = 1'b0;
      a = rnd();
      b = rnd();
      op = 1'($urandom);
    endtask
    task automatic noise();
      @(negedge clk);
      if (busy) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    endtask
    task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 500) begin
        @(negedge clk);
        n++;
      end
      ck("drain", 64'(q.size()), 64'(0));
    endtask
    task automatic zeros(input string p);
      ck({p, "_busy"}, 64'(busy), 64'(0));
      ck({p, "_done"}, 64'(done), 64'(0));
      ck({p, "_result"}, 64'(result), 64'(0));
      ck({p, "_carry"}, 64'(carry_out), 64'(0));
      ck({p, "_ovf"}, 64'(overflow), 64'(0));
      ck({p, "_zero"}, 64'(zero), 64'(0));
      ck({p, "_sign"}, 64'(sign), 64'(0));
    endtask
    initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      zeros("reset");
      issue(W'(64'hFF), W'(1), 1'b0);
      issue(W'(5), W'(5), 1'b1);
      issue(W'(1) << (W - 1), W'(1), 1'b1);
      issue(W'(3), W'(7), 1'b1);
      issue(rnd(), rnd(), 1'($urandom));
      noise();
      noise();
      issue(rnd(), rnd(), 1'b0);
      drain();
      repeat (3) @(negedge clk);
      ck("hold", 64'(result), 64'(last_r));
      issue(W'(64'h1234), W'(64'h5678), 1'b0);
      void'(q.pop_back());
      repeat (N / 2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (N + 2) @(negedge clk);
      zeros("abort");
      for (int i = 0; i < 1000; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue(rnd(), rnd(), 1'($urandom));
        if ($urandom_range(0, 3) == 0) noise();
      end
      drain();
      fin = 1'b1;
    end
  end
  initial begin
    for (int i = 0; i < 60000 && !(u[0].fin && u[1].fin && u[2].fin && u[3].fin); i++) @(posedge clk);
    if (!(u[0].fin && u[1].fin && u[2].fin && u[3].fin)) begin
      checks++;
      errors++;
      $display("FAIL global_timeout: got unfinished expected all finished");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
